// File: rtl/flex_timer_pkg.sv
// Shared types for the flex down-counting timer.
package flex_timer_pkg;

  // Timer FSM: IDLE holds the count, RUN lets prescaler ticks decrement it.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/flex_prescaler.sv
// Prescaler: emits one tick every prescale_val+1 enabled cycles.
module flex_prescaler #(
  parameter int NUM_PRE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [NUM_PRE_BITS-1:0] prescale_val,
  output logic                    tick
);

  localparam logic [NUM_PRE_BITS-1:0] PRE_ONE = NUM_PRE_BITS'(1);

  logic [NUM_PRE_BITS-1:0] pre_cnt;
  logic                    at_limit;

  // >= rather than == so a mid-run reduction of prescale_val cannot overshoot.
  assign at_limit = (pre_cnt >= prescale_val);
  assign tick     = enable & at_limit & ~clear;

  // Prescale counter: restarts on clear, holds while disabled, wraps at the limit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pre_cnt <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
    end else if (enable) begin
      if (at_limit) pre_cnt <= '0;
      else          pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

endmodule

// File: rtl/flex_down_timer.sv
// Loadable down-counting timer with prescaler, one-shot and auto-reload modes.
module flex_down_timer
  import flex_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_PRE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    auto_reload,
  input  logic [NUM_PRE_BITS-1:0] prescale_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    zero_flag,
  output logic                    expire_pulse,
  output logic                    running
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  timer_state_t            state, state_next;
  logic [NUM_CNT_BITS-1:0] count_next;
  logic [NUM_CNT_BITS-1:0] reload_reg, reload_next;
  logic                    expire_next;
  logic                    tick;

  assign running   = (state == RUN);
  assign zero_flag = (count_out == '0);

  // Load also restarts the prescaler so the first tick lands prescale_val+1 cycles later.
  flex_prescaler #(
    .NUM_PRE_BITS (NUM_PRE_BITS)
  ) u_prescaler (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear | load),
    .enable       (running & count_enable),
    .prescale_val (prescale_val),
    .tick         (tick)
  );

  // State, count, reload and expire registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      count_out    <= '0;
      reload_reg   <= '0;
      expire_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      count_out    <= count_next;
      reload_reg   <= reload_next;
      expire_pulse <= expire_next;
    end
  end

  // Next-state logic, priority clear > load > tick; expire defaults low every cycle.
  always_comb begin
    state_next  = state;
    count_next  = count_out;
    reload_next = reload_reg;
    expire_next = 1'b0;
    if (clear) begin
      count_next = '0;
      state_next = IDLE;
    end else if (load) begin
      count_next  = load_val;
      reload_next = load_val;
      state_next  = (load_val != '0) ? RUN : IDLE;
    end else if (tick) begin
      // Ticks only occur in RUN, where the count is never 0.
      if (count_out > CNT_ONE) begin
        count_next = count_out - CNT_ONE;
      end else begin
        expire_next = 1'b1;
        if (auto_reload) begin
          // Skip 0 so the period is exactly reload_reg ticks.
          count_next = reload_reg;
        end else begin
          count_next = '0;
          state_next = IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_flex_down_timer.sv
// Directed self-checking bench for flex_down_timer.
module tb_flex_down_timer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       count_enable;
  logic       auto_reload;
  logic [3:0] prescale_val;
  logic [3:0] count_out;
  logic       zero_flag;
  logic       expire_pulse;
  logic       running;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_q[$];
  logic       exp_exp_q[$];

  flex_down_timer #(
    .NUM_CNT_BITS (4),
    .NUM_PRE_BITS (4)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .auto_reload  (auto_reload),
    .prescale_val (prescale_val),
    .count_out    (count_out),
    .zero_flag    (zero_flag),
    .expire_pulse (expire_pulse),
    .running      (running)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance one cycle; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  // Pop expected count/expire pairs and compare one per cycle.
  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      step();
      check({tag, "_count"}, count_out, exp_q.pop_front());
      check({tag, "_expire"}, expire_pulse, exp_exp_q.pop_front());
    end
  endtask

  initial begin
    int cycles;
    bit seen;

    // Reset
    n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    count_enable = 1'b1; auto_reload = 1'b0; prescale_val = '0;
    #12;
    check("rst_count", count_out, 0);
    check("rst_zero", zero_flag, 1);
    check("rst_running", running, 0);
    check("rst_expire", expire_pulse, 0);
    n_rst = 1'b1;
    step();

    // One-shot, prescale 0, load 3 -> 3,2,1,0
    do_load(4'd3);
    check("os_load_count", count_out, 3);
    check("os_load_running", running, 1);
    exp_q = '{4'd2, 4'd1, 4'd0};
    exp_exp_q = '{1'b0, 1'b0, 1'b1};
    drain("os");
    check("os_running_fall", running, 0);
    check("os_zero", zero_flag, 1);
    step();
    check("os_idle_expire", expire_pulse, 0);
    check("os_idle_count", count_out, 0);

    // Auto-reload, prescale 2, load 2 -> period 6 cycles
    prescale_val = 4'd2; auto_reload = 1'b1;
    do_load(4'd2);
    check("ar_load_count", count_out, 2);
    exp_q = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd2};
    exp_exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drain("ar");
    check("ar_running", running, 1);
    check("ar_zero", zero_flag, 0);
    clear = 1'b1; step(); clear = 1'b0;
    check("clr_count", count_out, 0);
    check("clr_running", running, 0);
    auto_reload = 1'b0;

    // Pause: prescale 1, load 4; disable with prescaler mid-count
    prescale_val = 4'd1;
    do_load(4'd4);
    exp_q = '{4'd4, 4'd3, 4'd3};
    exp_exp_q = '{1'b0, 1'b0, 1'b0};
    drain("pz_pre");
    count_enable = 1'b0;
    exp_q = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
    exp_exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drain("pz_hold");
    count_enable = 1'b1;
    // Prescaler held at 1, so the first resumed cycle ticks.
    exp_q = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
    exp_exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drain("pz_resume");

    // Priority: clear+load when expiry is due
    prescale_val = 4'd0;
    do_load(4'd2);
    step();
    check("pr_pre_count", count_out, 1);
    clear = 1'b1; load = 1'b1; load_val = 4'd5;
    step();
    clear = 1'b0; load = 1'b0;
    check("pr_clr_count", count_out, 0);
    check("pr_clr_expire", expire_pulse, 0);
    check("pr_clr_running", running, 0);
    // Load 7 when expiry is due
    do_load(4'd2);
    step();
    do_load(4'd7);
    check("pr_ld_count", count_out, 7);
    check("pr_ld_expire", expire_pulse, 0);
    check("pr_ld_running", running, 1);
    step();
    check("pr_ld_next", count_out, 6);

    // Reset mid-run
    do_load(4'd5);
    step(); step();
    check("mr_pre_count", count_out, 3);
    #2 n_rst = 1'b0;
    #1;
    check("mr_count", count_out, 0);
    check("mr_running", running, 0);
    check("mr_expire", expire_pulse, 0);
    check("mr_zero", zero_flag, 1);
    #2 n_rst = 1'b1;
    step();

    // Load 0: never runs, never expires
    do_load(4'd0);
    check("l0_running", running, 0);
    check("l0_count", count_out, 0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (expire_pulse) seen = 1'b1;
    end
    check("l0_no_expire", seen, 0);

    // Max load and prescale: expiry exactly 240 cycles after load
    prescale_val = 4'd15;
    do_load(4'd15);
    cycles = 0;
    seen = 1'b0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      step();
      if (i == 16) check("max_count16", count_out, 14);
      if (expire_pulse) begin
        seen = 1'b1;
        cycles = i;
      end
    end
    check("max_seen", seen, 1);
    check("max_cycles", cycles, 240);
    check("max_count_end", count_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flex_down_timer.md
Name: flex_down_timer

Overview:
- Loadable down-counting timer with an integrated prescaler; the counterpart to the team's up-counting flex counter.
- Counts from a loaded value toward zero and signals expiry. Supports one-shot and auto-reload (periodic) modes.
- Used by SD/USB protocol blocks for timeouts, bit-period timing and response-wait windows.

Parameters:
- NUM_CNT_BITS, 4, width of the main count and load value.
- NUM_PRE_BITS, 4, width of the prescaler count and prescale value.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort: zeroes the count, stops the timer.
- load  input  1  synchronous load of load_val; starts the timer.
- load_val  input  NUM_CNT_BITS  start/reload value, in ticks.
- count_enable  input  1  pauses prescaler and counter when low.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at expiry.
- prescale_val  input  NUM_PRE_BITS  tick occurs every prescale_val+1 enabled cycles.
- count_out  output  NUM_CNT_BITS  current remaining count (registered).
- zero_flag  output  1  high when count_out == 0.
- expire_pulse  output  1  one-cycle registered pulse on expiry.
- running  output  1  high while in the RUN state.

Behaviour:
- Reset (n_rst low, asynchronous), all values held until n_rst releases:
  - count_out=0, reload register=0, prescaler=0.
  - expire_pulse=0, running=0, state=IDLE.
  - zero_flag=1, because it is decoded from count_out.
- State machine has two states, IDLE and RUN; running = (state==RUN).
- Priority each cycle: clear > load > tick.
- clear:
  - Sets count_out=0, prescaler=0, expire_pulse=0, state=IDLE.
  - Reload register is unchanged.
- load (when clear is low):
  - count_out<=load_val, reload register<=load_val, prescaler<=0, expire_pulse<=0.
  - state<=RUN if load_val!=0, else IDLE.
  - Loading 0 never produces expire_pulse.
  - load while in RUN restarts the timer; a pending expiry in the same cycle is discarded.
- Prescaler (RUN, count_enable=1, no clear/load):
  - If prescaler >= prescale_val: prescaler<=0 and a tick is generated.
  - Otherwise prescaler increments.
  - Using >= keeps a mid-run reduction of prescale_val from overshooting.
  - prescale_val=0 gives a tick on every enabled cycle.
- count_enable=0 holds the prescaler and count_out; expire_pulse drops to 0.
- On a tick:
  - count_out>1: count_out decrements by 1.
  - count_out==1 with auto_reload=0: count_out<=0, state<=IDLE, expire_pulse<=1.
  - count_out==1 with auto_reload=1: count_out<=reload register, state stays RUN, expire_pulse<=1. The counter never shows 0, so the period is exactly reload_val ticks.
- expire_pulse is high for exactly one cycle per expiry and is 0 in every cycle without an expiry.
- In IDLE, ticks are ignored and count_out holds; the prescaler stays at 0.
- Width rules:
  - No arithmetic wraps below 0; decrement only happens when count_out>1.
  - The maximum load value 2^NUM_CNT_BITS-1 is legal.
- Latency: one cycle from the load edge to running=1; the first tick arrives prescale_val+1 enabled cycles after load.

Decomposition:
- Package flex_timer_pkg holds the state enum timer_state_t {IDLE, RUN}.
- Sub-module flex_prescaler (NUM_PRE_BITS):
  - Inputs: clk, n_rst, clear (asserted on clear or load), enable (running & count_enable), prescale_val.
  - Output: tick.
- The top level holds the FSM, count register, reload register and expire register.

Test Plan:
- Reset mid-run: load 5, wait 2 ticks, assert n_rst=0 asynchronously -> count_out=0, running=0, expire_pulse=0, zero_flag=1 immediately.
- One-shot: prescale_val=0, load 3, enable held -> count_out 3,2,1,0 on consecutive cycles; expire_pulse=1 only in the cycle count_out becomes 0; running falls the same cycle.
- Auto-reload with prescale: prescale_val=2, load 2, auto_reload=1 -> count_out changes every 3 cycles: 2,1,2,1…; expire_pulse every 6 cycles; zero_flag never asserts.
- Pause: load 4, prescale_val=1, drop count_enable for 5 cycles after the first tick -> count_out holds at 3 and the prescaler holds; resuming continues with no lost or extra ticks.
- Priority: in the cycle count_out==1 and a tick is due, assert clear with load -> count_out=0, no expire_pulse; separately, load 7 in that cycle -> count_out=7, no expire_pulse.
- Edge values: load 0 -> running=0, no expire; load 15 (4-bit), prescale_val=15 -> expiry after exactly 240 enabled cycles.
